counter_limit_multimode: RTL and testbench
==========================================

# counter_limit_multimode

Parametrised up/down counter with programmable terminal limit, periodic or one-shot operation, synchronous load and clear, and a registered single-cycle wrap pulse. It is the general-purpose timebase/event counter for lab designs: it replaces fixed 8-bit auto-resetting counters and drives tick generators, PWM periods and timeouts from a single clock domain.

## Interface
- WIDTH, 8, counter and limit width in bits (>= 2)
- WRAP_CNT_W, 8, width of the wrap-event counter (used only with COUNTER_WRAP_CNT_EN)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable, sampled at posedge
- clr  input  1  synchronous clear
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value written on load
- limit  input  WIDTH  terminal limit, unsigned, sampled every cycle
- dir  input  1  0 = count up, 1 = count down
- one_shot  input  1  0 = periodic reload, 1 = stop at terminal
- value  output  WIDTH  current count, registered
- wrap  output  1  one-cycle pulse on each terminal event, registered
- done  output  1  sticky one-shot completion flag, registered
- wrap_cnt  output  WRAP_CNT_W  wrap-event count (present only with COUNTER_WRAP_CNT_EN)

## Operation
- Reset (async, any time, including mid-count): value=0, wrap=0, done=0, wrap_cnt=0; held while rst=1.
- Per-edge priority: clr > load > en. Lower-priority inputs are ignored in the same cycle.
- clr: value <= 0 if dir=0, value <= limit if dir=1; done <= 0; wrap <= 0.
- load: value <= load_value (no clipping to limit); done <= 0; wrap <= 0.
- Terminal condition T: up (dir=0): value >= limit; down (dir=1): value == 0.
- en=1, done=0, T=0: value <= value+1 (up) or value-1 (down); wrap <= 0.
- en=1, done=0, T=1, one_shot=0: value <= 0 (up) or limit (down); wrap <= 1.
- en=1, done=0, T=1, one_shot=1: value holds; wrap <= 1; done <= 1.
- done=1: en has no effect, value holds, wrap stays 0, until clr or load.
- en=0: value, done hold; wrap <= 0.
- Terminal is evaluated only on enabled cycles; an out-of-range value does not autoreset while en=0.
- Arithmetic is unsigned modulo 2^WIDTH; up never passes limit except via load; down never underflows (0 is terminal).
- limit=0: up mode wraps on every enabled cycle with value=0; down mode likewise.
- limit lowered below value in up mode: next enabled cycle is terminal (reload to 0). In down mode counting continues normally to 0.
- dir/one_shot changes take effect on the next edge; value is not modified by the change.

## Timing
- All outputs registered; response visible one clk after the sampling edge.
- wrap is high for exactly one cycle per terminal event; consecutive enabled terminal cycles (limit=0) give wrap held high continuously.
- Periodic up period: limit+1 enabled cycles from value=0 to next wrap; periodic down period: limit+1 enabled cycles from value=limit.
- One-shot: done rises in the same cycle as the single wrap pulse.
- No combinational path from inputs to outputs.

## Configuration
- COUNTER_WRAP_CNT_EN defined: wrap_cnt port exists; increments by 1 on every cycle in which wrap is asserted (same edge wrap is set), saturates at 2^WRAP_CNT_W-1, cleared by rst and clr, unaffected by load.
- Not defined: wrap_cnt port and its register are absent; all other behaviour identical.

## Test plan
- WIDTH=8, limit=5, dir=0, one_shot=0, en=1 from reset -> value 0,1,2,3,4,5,0,1...; wrap high one cycle with value returning to 0; period 6 cycles.
- dir=1, limit=3, clr pulse then en=1 -> value 3,2,1,0,3; wrap once per 4 cycles; wrap_cnt=2 after 8 enabled cycles (macro on).
- one_shot=1, limit=2, en=1 continuous -> value 0,1,2 then holds 2; wrap single pulse; done=1 sticky; load 0 clears done and counting resumes.
- load_value=200 with limit=10 up, en=1 -> value 200 then 0 next cycle with wrap=1; clr+load+en same edge -> value=0 (clr wins).
- Assert rst asynchronously mid-count (value=4, between edges) -> value, wrap, done, wrap_cnt go to 0 immediately, remain 0 until rst released.
- limit=0, en=1 for 3 cycles -> value stays 0, wrap high 3 consecutive cycles; en=0 -> wrap drops next cycle, value holds.

Source files
------------

// File: rtl/counter_limit_multimode_if.sv
// counter_limit_multimode_if: control/status bundle of the limit counter; wrap_cnt exists only with COUNTER_WRAP_CNT_EN
interface counter_limit_multimode_if #(
  parameter int WIDTH      = 8,
  parameter int WRAP_CNT_W = 8
);
  if (WIDTH < 2 || WRAP_CNT_W < 1) $error("counter_limit_multimode_if: WIDTH must be >= 2, WRAP_CNT_W >= 1");
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic             dir;
  logic             one_shot;
  logic [WIDTH-1:0] value;
  logic             wrap;
  logic             done;
`ifdef COUNTER_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt;
`endif
  modport master (
    output en, clr, load, load_value, limit, dir, one_shot,
`ifdef COUNTER_WRAP_CNT_EN
    input  wrap_cnt,
`endif
    input  value, wrap, done
  );
  modport slave (
    input  en, clr, load, load_value, limit, dir, one_shot,
`ifdef COUNTER_WRAP_CNT_EN
    output wrap_cnt,
`endif
    output value, wrap, done
  );
endinterface

// File: rtl/counter_limit_multimode.sv
// counter_limit_multimode: up/down counter with programmable limit, periodic/one-shot modes and wrap pulse; COUNTER_WRAP_CNT_EN adds a saturating wrap-event counter
module counter_limit_multimode #(
  parameter int WIDTH      = 8,
  parameter int WRAP_CNT_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  counter_limit_multimode_if.slave bus
);
  if (WIDTH < 2 || WRAP_CNT_W < 1) $error("counter_limit_multimode: WIDTH must be >= 2, WRAP_CNT_W >= 1");
  logic [WIDTH-1:0] value_q, value_d, reload;
  logic             wrap_q, wrap_d, done_q, done_d, step, term;
  // next state: clr beats load beats en; terminal only evaluated on enabled, not-done cycles
  always_comb begin
    reload  = bus.dir ? bus.limit : '0;
    term    = bus.dir ? (value_q == '0) : (value_q >= bus.limit);
    step    = bus.en && !done_q && !bus.clr && !bus.load;
    value_d = bus.clr ? reload :
              bus.load ? bus.load_value :
              !step ? value_q :
              !term ? (bus.dir ? value_q - WIDTH'(1) : value_q + WIDTH'(1)) :
              bus.one_shot ? value_q : reload;
    wrap_d  = step && term;
    done_d  = (bus.clr || bus.load) ? 1'b0 : (done_q || (step && term && bus.one_shot));
  end
  // counter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end
  assign bus.value = value_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;
`ifdef COUNTER_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  // counts wrap events on the same edge wrap is set, saturating; load leaves it alone
  always_comb wrap_cnt_d = bus.clr ? '0 : (wrap_d && !(&wrap_cnt_q)) ? wrap_cnt_q + WRAP_CNT_W'(1) : wrap_cnt_q;
  // wrap-event counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_cnt_q <= '0;
    else     wrap_cnt_q <= wrap_cnt_d;
  end
  assign bus.wrap_cnt = wrap_cnt_q;
`endif
endmodule

// File: tb/tb_counter_limit_multimode.sv
// tb_counter_limit_multimode: table-driven checks of counter_limit_multimode plus async-reset sequence
module tb_counter_limit_multimode;
  typedef struct {
    logic       clr, load, en, dir, os;
    logic [7:0] lv, lim, v;
    logic       w, d;
    logic [7:0] wc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  counter_limit_multimode_if #(.WIDTH(8), .WRAP_CNT_W(8)) bus ();
  counter_limit_multimode #(.WIDTH(8), .WRAP_CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic vec_t mk(input logic clr, load, en, dir, os, input logic [7:0] lv, lim, v,
                              input logic w, d, input logic [7:0] wc);
    vec_t t;
    t.clr = clr; t.load = load; t.en = en; t.dir = dir; t.os = os;
    t.lv = lv; t.lim = lim; t.v = v; t.w = w; t.d = d; t.wc = wc;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    bus.clr = t.clr; bus.load = t.load; bus.en = t.en; bus.dir = t.dir;
    bus.one_shot = t.os; bus.load_value = t.lv; bus.limit = t.lim;
  endtask

  initial begin
    // periodic up, limit 5: 1..5 then wrap to 0
    for (int i = 1; i <= 5; i++) q.push_back(mk(0,0,1,0,0,0,5,8'(i),0,0,0));
    q.push_back(mk(0,0,1,0,0,0,5,0,1,0,1));
    q.push_back(mk(0,0,1,0,0,0,5,1,0,0,1));
    // periodic down, limit 3: clr loads limit, 2,1,0,3(wrap) twice
    q.push_back(mk(1,0,0,1,0,0,3,3,0,0,0));
    q.push_back(mk(0,0,1,1,0,0,3,2,0,0,0));
    q.push_back(mk(0,0,1,1,0,0,3,1,0,0,0));
    q.push_back(mk(0,0,1,1,0,0,3,0,0,0,0));
    q.push_back(mk(0,0,1,1,0,0,3,3,1,0,1));
    q.push_back(mk(0,0,1,1,0,0,3,2,0,0,1));
    q.push_back(mk(0,0,1,1,0,0,3,1,0,0,1));
    q.push_back(mk(0,0,1,1,0,0,3,0,0,0,1));
    q.push_back(mk(0,0,1,1,0,0,3,3,1,0,2));
    // one-shot up, limit 2: stops at 2 with sticky done; load 0 restarts
    q.push_back(mk(1,0,0,0,1,0,2,0,0,0,0));
    q.push_back(mk(0,0,1,0,1,0,2,1,0,0,0));
    q.push_back(mk(0,0,1,0,1,0,2,2,0,0,0));
    q.push_back(mk(0,0,1,0,1,0,2,2,1,1,1));
    q.push_back(mk(0,0,1,0,1,0,2,2,0,1,1));
    q.push_back(mk(0,0,1,0,1,0,2,2,0,1,1));
    q.push_back(mk(0,1,1,0,1,0,2,0,0,0,1));
    q.push_back(mk(0,0,1,0,1,0,2,1,0,0,1));
    q.push_back(mk(0,0,1,0,1,0,2,2,0,0,1));
    q.push_back(mk(0,0,1,0,1,0,2,2,1,1,2));
    // load above limit is terminal on next enabled cycle
    q.push_back(mk(0,1,1,0,0,200,10,200,0,0,2));
    q.push_back(mk(0,0,1,0,0,0,10,0,1,0,3));
    q.push_back(mk(0,0,1,0,0,0,10,1,0,0,3));
    // clr wins over load and en
    q.push_back(mk(1,1,1,0,0,77,10,0,0,0,0));
    // limit 0: wrap every enabled cycle, drops when en goes low
    q.push_back(mk(0,0,1,0,0,0,0,0,1,0,1));
    q.push_back(mk(0,0,1,0,0,0,0,0,1,0,2));
    q.push_back(mk(0,0,1,0,0,0,0,0,1,0,3));
    q.push_back(mk(0,0,0,0,0,0,0,0,0,0,3));

    drive(mk(0,0,0,0,0,0,5,0,0,0,0));
    rst = 1'b1;
    step();
    step();
    chk("reset value", 32'(bus.value), 0);
    chk("reset wrap", 32'(bus.wrap), 0);
    chk("reset done", 32'(bus.done), 0);
    rst = 1'b0;

    foreach (q[i]) begin
      drive(q[i]);
      step();
      chk($sformatf("vec%0d value", i), 32'(bus.value), 32'(q[i].v));
      chk($sformatf("vec%0d wrap", i), 32'(bus.wrap), 32'(q[i].w));
      chk($sformatf("vec%0d done", i), 32'(bus.done), 32'(q[i].d));
`ifdef COUNTER_WRAP_CNT_EN
      chk($sformatf("vec%0d wrap_cnt", i), 32'(bus.wrap_cnt), 32'(q[i].wc));
`endif
    end

    // async reset between edges while counting at value 4
    drive(mk(1,0,0,0,0,0,9,0,0,0,0));
    step();
    drive(mk(0,0,1,0,0,0,9,0,0,0,0));
    repeat (4) step();
    chk("pre-reset value", 32'(bus.value), 4);
    #3;
    rst = 1'b1;
    #1;
    chk("async reset value", 32'(bus.value), 0);
    chk("async reset wrap", 32'(bus.wrap), 0);
    chk("async reset done", 32'(bus.done), 0);
`ifdef COUNTER_WRAP_CNT_EN
    chk("async reset wrap_cnt", 32'(bus.wrap_cnt), 0);
`endif
    step();
    step();
    chk("reset held value", 32'(bus.value), 0);
    rst = 1'b0;
    step();
    chk("post-reset value", 32'(bus.value), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
